// File: rtl/lsu_pkg.sv
// Shared types, lane masks and request-legality helpers for the LSU bus controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_MISALIGN = 2'd0,
        CAUSE_BUSERR   = 2'd1,
        CAUSE_TIMEOUT  = 2'd2
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    // Unsigned bit is meaningful only for B/H loads; anything else with it set is rejected.
    function automatic logic access_legal(input logic [2:0] funct3, input logic we,
                                          input logic [1:0] off);
        logic legal;
        case (size_e'(funct3[1:0]))
            SIZE_B:  legal = 1'b1;
            SIZE_H:  legal = (off != 2'd3);
            SIZE_W:  legal = (off == 2'd0);
            default: legal = 1'b0;
        endcase
        if (funct3[2] && (we || funct3[1:0] == SIZE_W)) legal = 1'b0;
        return legal;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_B:  return LANE_B << off;
            SIZE_H:  return LANE_H << off;
            default: return LANE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_aligner.sv
// Right-justifies the addressed bytes of a bus read word and zero/sign-extends B/H loads.
module lsu_load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] dat_i,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        sign;

    always_comb begin
        shifted = dat_i >> {off, 3'b000};
        sign    = 1'b0;
        rdata   = shifted;
        case (size_e'(size))
            SIZE_B: begin
                sign  = ~uns & shifted[7];
                rdata = {{24{sign}}, shifted[7:0]};
            end
            SIZE_H: begin
                sign  = ~uns & shifted[15];
                rdata = {{16{sign}}, shifted[15:0]};
            end
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_controller.sv
// Sequences one load/store at a time onto the data bus and returns data or an exception.
// Optional bus timeout abort is enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_bus_controller
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [1:0]  rsp_cause,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack,
    input  logic        bus_err
);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_exc_q, rsp_exc_d;
    logic [1:0]  rsp_cause_q, rsp_cause_d;
    logic        bus_cyc_q, bus_cyc_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_adr_q, bus_adr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_dat_o_q, bus_dat_o_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_data;
    logic        timeout_hit;

    lsu_load_aligner u_aligner (
        .dat_i (bus_dat_i),
        .size  (size_q),
        .uns   (uns_q),
        .off   (off_q),
        .rdata (load_data)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holding the count at zero outside BUS is what clears it on every entry.
    always_comb begin
        cnt_d       = (state_q == ST_BUS) ? cnt_q + 1'b1 : '0;
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_exc_d   = 1'b0;
        rsp_cause_d = '0;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_adr_d   = bus_adr_q;
        bus_sel_d   = bus_sel_q;
        bus_dat_o_d = bus_dat_o_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                req_ready_d = 1'b0;
                size_d      = size_e'(req_funct3[1:0]);
                uns_d       = req_funct3[2];
                off_d       = req_addr[1:0];
                if (access_legal(req_funct3, req_we, req_addr[1:0])) begin
                    state_d     = ST_BUS;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = req_we;
                    bus_adr_d   = {req_addr[31:2], 2'b00};
                    bus_sel_d   = lane_mask(size_e'(req_funct3[1:0]), req_addr[1:0]);
                    bus_dat_o_d = req_wdata << {req_addr[1:0], 3'b000};
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = 1'b1;
                    rsp_cause_d = CAUSE_MISALIGN;
                end
            end
            ST_BUS: if (bus_err || bus_ack || timeout_hit) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                bus_cyc_d   = 1'b0;
                bus_we_d    = 1'b0;
                bus_adr_d   = '0;
                bus_sel_d   = '0;
                bus_dat_o_d = '0;
                // Error outranks a simultaneous ack; timeout only applies when neither arrived.
                if (bus_err) begin
                    rsp_exc_d   = 1'b1;
                    rsp_cause_d = CAUSE_BUSERR;
                end else if (bus_ack) begin
                    rsp_rdata_d = bus_we_q ? '0 : load_data;
                end else begin
                    rsp_exc_d   = 1'b1;
                    rsp_cause_d = CAUSE_TIMEOUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_exc_q   <= 1'b0;
            rsp_cause_q <= '0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_adr_q   <= '0;
            bus_sel_q   <= '0;
            bus_dat_o_q <= '0;
            size_q      <= SIZE_B;
            uns_q       <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_exc_q   <= rsp_exc_d;
            rsp_cause_q <= rsp_cause_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_adr_q   <= bus_adr_d;
            bus_sel_q   <= bus_sel_d;
            bus_dat_o_q <= bus_dat_o_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_exc   = rsp_exc_q;
    assign rsp_cause = rsp_cause_q;
    assign bus_cyc   = bus_cyc_q;
    assign bus_stb   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_adr   = bus_adr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_dat_o = bus_dat_o_q;

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Directed plus randomized bench for lsu_bus_controller against a byte-level reference model.
module tb_lsu_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_exc;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_cause;
    logic        bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
    logic [3:0]  bus_sel;
    logic        bus_ack, bus_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_exc    (rsp_exc),
        .rsp_cause  (rsp_cause),
        .bus_cyc    (bus_cyc),
        .bus_stb    (bus_stb),
        .bus_we     (bus_we),
        .bus_adr    (bus_adr),
        .bus_sel    (bus_sel),
        .bus_dat_o  (bus_dat_o),
        .bus_dat_i  (bus_dat_i),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: works from access width in bytes rather than encodings or shifts.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_legal(input logic we, input logic [2:0] f3, input int off);
        if (f3[1:0] == 2'd3) return 1'b0;
        if (f3[2] && (we || nbytes(f3) == 4)) return 1'b0;
        return (off + nbytes(f3) <= 4) && (off % nbytes(f3) == 0 || nbytes(f3) == 2);
    endfunction

    function automatic logic [3:0] model_sel(input logic [2:0] f3, input int off);
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nbytes(f3));
        return s;
    endfunction

    function automatic logic [31:0] model_dat_o(input logic [31:0] wdata, input int off);
        logic [31:0] d = '0;
        for (int i = off; i < 4; i++) d[8*i +: 8] = wdata[8*(i-off) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] f3, input int off,
                                                input logic [31:0] word);
        logic [31:0] v = '0;
        int          n = nbytes(f3);
        for (int k = 0; k < n && off + k < 4; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    // Issues one request from a negedge; `delay` BUS cycles pass before ack/err is driven.
    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] word, input int delay,
                              input logic ack, input logic err);
        int   off   = int'(addr[1:0]);
        logic legal = model_legal(we, f3, off);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (legal) begin
            for (int i = 0; i <= delay; i++) begin
                check({tag, ".cyc"}, 32'(bus_cyc), 32'd1);
                if (i == 0) begin
                    check({tag, ".stb"}, 32'(bus_stb), 32'd1);
                    check({tag, ".we"}, 32'(bus_we), 32'(we));
                    check({tag, ".adr"}, bus_adr, {addr[31:2], 2'b00});
                    check({tag, ".sel"}, 32'(bus_sel), 32'(model_sel(f3, off)));
                    check({tag, ".dat_o"}, bus_dat_o, model_dat_o(wdata, off));
                    check({tag, ".busy"}, {30'd0, req_ready, rsp_valid}, 32'd0);
                end
                if (i == delay) begin
                    bus_ack   = ack;
                    bus_err   = err;
                    bus_dat_i = word;
                end
                @(negedge clk);
            end
            bus_ack = 1'b0;
            bus_err = 1'b0;
            check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".rsp_exc"}, 32'(rsp_exc), 32'(err));
            check({tag, ".rsp_cause"}, 32'(rsp_cause), err ? 32'd1 : 32'd0);
            check({tag, ".rsp_rdata"}, rsp_rdata,
                  (err || we) ? 32'd0 : model_rdata(f3, off, word));
            check({tag, ".cyc_drop"}, 32'(bus_cyc), 32'd0);
        end else begin
            check({tag, ".no_cyc"}, 32'(bus_cyc), 32'd0);
            check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".rsp_exc"}, 32'(rsp_exc), 32'd1);
            check({tag, ".rsp_cause"}, 32'(rsp_cause), 32'd0);
            check({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        end
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        bus_dat_i  = '0;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        #12;
        check("reset.ready", 32'(req_ready), 32'd1);
        check("reset.outs", {28'd0, rsp_valid, rsp_exc, bus_cyc, bus_stb}, 32'd0);
        check("reset.bus", bus_adr | bus_dat_o | 32'(bus_sel) | 32'(bus_we), 32'd0);
        check("reset.rsp", rsp_rdata | 32'(rsp_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_access("sw",  1'b1, 3'b010, 32'h100, 32'hdeadbeef, 32'h0, 2, 1'b1, 1'b0);
        run_access("lb",  1'b0, 3'b000, 32'h203, 32'h0, 32'h80000000, 0, 1'b1, 1'b0);
        run_access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80000000, 1, 1'b1, 1'b0);
        run_access("sh3", 1'b1, 3'b001, 32'h3, 32'h1234, 32'h0, 0, 1'b1, 1'b0);
        run_access("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        run_access("lh1_err", 1'b0, 3'b001, 32'h1, 32'h0, 32'h0000ff00, 1, 1'b1, 1'b1);
        run_access("lhu2", 1'b0, 3'b101, 32'h2, 32'h0, 32'h9abc1234, 0, 1'b1, 1'b0);
        run_access("sbu", 1'b1, 3'b100, 32'h0, 32'h55, 32'h0, 0, 1'b1, 1'b0);
        run_access("lwu", 1'b0, 3'b110, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        run_access("ill", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0);

        // Stalled transfer: either aborted after four BUS cycles or held until acknowledged.
        check("to.ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check("to.cyc_held", 32'(bus_cyc), 32'd1);
            @(negedge clk);
        end
        check("to.cyc_drop", 32'(bus_cyc), 32'd0);
        check("to.rsp", {29'd0, rsp_valid, rsp_exc, 1'b0}, 32'd6);
        check("to.cause", 32'(rsp_cause), 32'd2);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("to.late_ack", {30'd0, rsp_valid, bus_cyc}, 32'd0);
        check("to.ready_back", 32'(req_ready), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            check("to.cyc_held", 32'(bus_cyc), 32'd1);
            @(negedge clk);
        end
        bus_ack   = 1'b1;
        bus_dat_i = 32'h0badf00d;
        @(negedge clk);
        bus_ack = 1'b0;
        check("to.rsp", {30'd0, rsp_valid, rsp_exc}, 32'd2);
        check("to.rdata", rsp_rdata, 32'h0badf00d);
        @(negedge clk);
        check("to.ready_back", 32'(req_ready), 32'd1);
`endif

        // Reset while the bus cycle is open: no response, bus released at once.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h81;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst.cyc_before", 32'(bus_cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst.cyc_stb", {30'd0, bus_cyc, bus_stb}, 32'd0);
        check("rst.no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus_ack = 1'b1;
        check("rst.ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.ack_ignored", {30'd0, rsp_valid, bus_cyc}, 32'd0);
        end
        bus_ack = 1'b0;

        for (int n = 0; n < 60; n++) begin
            logic err = ($urandom_range(0, 7) == 0);
            logic ack = !err || $urandom_range(0, 1) == 1;
            run_access("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), ack, err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
